dec_2to4: RTL and testbench
===========================

// Module: dec_2to4
//
// PURPOSE
//   Registered 2-to-4 line decoder. Two select bits (a = LSB, b = MSB) drive
//   exactly one of four outputs active for one qualified cycle.
//   Used as a small address/select decoder feeding chip-select or mux-enable
//   logic. Outputs are registered to give clean, glitch-free selects.
//
// PARAMETERS
//   ACTIVE_LOW   0   0: selected output = 1, others = 0; 1: selected = 0, others = 1
//   CNT_W        8   width of the optional hit counters (only used when DEC_HIT_COUNT_EN)
//
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   rst       in   1      reset, synchronous, active-high
//   en        in   1      decode enable; sampled with a/b
//   a         in   1      select bit 0 (LSB)
//   b         in   1      select bit 1 (MSB)
//   y0        out  1      active when {b,a} = 2'b00
//   y1        out  1      active when {b,a} = 2'b01
//   y2        out  1      active when {b,a} = 2'b10
//   y3        out  1      active when {b,a} = 2'b11
//   valid     out  1      1 when y0..y3 reflect a decoded select
//   hit_cnt0..hit_cnt3  out  CNT_W  per-output decode counts (DEC_HIT_COUNT_EN only)
//
// BEHAVIOUR
//   - Index sel = {b,a}. At rising clk with en=1: y[sel] <= active level,
//     the other three <= inactive level, valid <= 1. Latency: 1 cycle.
//   - en=0 at a rising clk: all y <= inactive level, valid <= 0 (no hold).
//   - Exactly one y is active whenever valid=1; none when valid=0.
//   - Reset: rst=1 at a rising clk forces all y to inactive level
//     (0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1), valid=0, counters=0.
//     rst has priority over en; asserting rst mid-stream clears on that edge.
//   - Back-to-back selects: each cycle's en/a/b fully replaces the previous
//     output; no extra bubbles, one decode per cycle.
//   - X/Z on a or b with en=1 is not required to be handled; inputs assumed
//     known when en=1.
//
// CONFIGURATION
//   DEC_HIT_COUNT_EN defined: adds hit_cnt0..hit_cnt3 ports. On each rising
//     clk with en=1 and rst=0, hit_cnt[sel] increments by 1, saturating at
//     2**CNT_W-1 (no wrap). Counters clear on rst. Counters update in the
//     same cycle as y (value visible 1 cycle after the decode sample).
//   DEC_HIT_COUNT_EN undefined: hit_cnt ports and counter logic absent;
//     decoder behaviour otherwise identical.
//
// TESTING
//   1. rst=1 two cycles -> y0..y3=0000, valid=0 (ACTIVE_LOW=0); =1111 if ACTIVE_LOW=1.
//   2. en=1, {b,a}=00,01,10,11 on successive cycles -> next-cycle
//      {y3,y2,y1,y0}=0001,0010,0100,1000, valid=1 each cycle.
//   3. en=1 {b,a}=10, then en=0 -> y2=1 valid=1, then all y=0 valid=0.
//   4. rst=1 concurrent with en=1 {b,a}=11 -> y all inactive, valid=0 after edge.
//   5. ACTIVE_LOW=1, en=1 {b,a}=01 -> {y3,y2,y1,y0}=1101, valid=1.
//   6. DEC_HIT_COUNT_EN, CNT_W=2: select 00 for 5 cycles -> hit_cnt0 = 1,2,3,3,3;
//      others stay 0; rst -> all 0.

Source files
------------

// File: rtl/dec_2to4.sv
// Registered 2-to-4 line decoder with configurable output polarity.
// Define DEC_HIT_COUNT_EN to add saturating per-output hit counters.
module dec_2to4 #(
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic             y0,
    output logic             y1,
    output logic             y2,
    output logic             y3,
`ifdef DEC_HIT_COUNT_EN
    output logic [CNT_W-1:0] hit_cnt0,
    output logic [CNT_W-1:0] hit_cnt1,
    output logic [CNT_W-1:0] hit_cnt2,
    output logic [CNT_W-1:0] hit_cnt3,
`endif
    output logic             valid
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam logic [3:0] YInactive = {4{ACTIVE_LOW}};

    logic [1:0] sel;
    logic [3:0] onehot;
    logic [3:0] y_d, y_q;
    logic       valid_d, valid_q;

    assign sel = {b, a};

    always_comb begin
        onehot = 4'b0000;
        unique case (sel)
            2'b00: onehot = 4'b0001;
            2'b01: onehot = 4'b0010;
            2'b10: onehot = 4'b0100;
            2'b11: onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

    // Disabled cycles drop back to idle; the previous select is never held.
    always_comb begin
        y_d     = YInactive;
        valid_d = 1'b0;
        if (en) begin
            y_d     = onehot ^ YInactive;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= YInactive;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y0    = y_q[0];
    assign y1    = y_q[1];
    assign y2    = y_q[2];
    assign y3    = y_q[3];
    assign valid = valid_q;

`ifdef DEC_HIT_COUNT_EN
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] cnt_q [4];

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en && onehot[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign hit_cnt0 = cnt_q[0];
    assign hit_cnt1 = cnt_q[1];
    assign hit_cnt2 = cnt_q[2];
    assign hit_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_dec_2to4.sv
// Bench for dec_2to4: fixed vector table, random traffic against a reference model,
// both output polarities side by side; hit counters checked when DEC_HIT_COUNT_EN is set.
module tb_dec_2to4;

    localparam int unsigned CntW   = 2;
    localparam int          CntMax = (1 << CntW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;

    logic hy0, hy1, hy2, hy3, hvalid;
    logic ly0, ly1, ly2, ly3, lvalid;
`ifdef DEC_HIT_COUNT_EN
    logic [CntW-1:0] hc0, hc1, hc2, hc3;
    logic [CntW-1:0] lc0, lc1, lc2, lc3;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: selected index (-1 = none) and per-output hit counts.
    int exp_idx = -1;
    int exp_cnt [4];

    always #5 clk = ~clk;

    dec_2to4 #(.ACTIVE_LOW(1'b0), .CNT_W(CntW)) u_dut_hi (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .y0(hy0), .y1(hy1), .y2(hy2), .y3(hy3),
`ifdef DEC_HIT_COUNT_EN
        .hit_cnt0(hc0), .hit_cnt1(hc1), .hit_cnt2(hc2), .hit_cnt3(hc3),
`endif
        .valid(hvalid)
    );

    dec_2to4 #(.ACTIVE_LOW(1'b1), .CNT_W(CntW)) u_dut_lo (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .y0(ly0), .y1(ly1), .y2(ly2), .y3(ly3),
`ifdef DEC_HIT_COUNT_EN
        .hit_cnt0(lc0), .hit_cnt1(lc1), .hit_cnt2(lc2), .hit_cnt3(lc3),
`endif
        .valid(lvalid)
    );

    typedef struct {
        logic       r;
        logic       e;
        logic       sa;
        logic       sb;
        logic [3:0] y;     // {y3,y2,y1,y0} for the active-high instance
        logic       v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then settle past it.
    task automatic cycle(input logic r, input logic e, input logic sa, input logic sb);
        @(negedge clk);
        rst = r; en = e; a = sa; b = sb;
        @(posedge clk);
        if (r) begin
            exp_idx = -1;
            for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        end else if (e) begin
            exp_idx = 2 * int'(sb) + int'(sa);
            if (exp_cnt[exp_idx] < CntMax) exp_cnt[exp_idx]++;
        end else begin
            exp_idx = -1;
        end
        #1;
    endtask

    function automatic logic [3:0] model_y(input bit low);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = ((i == exp_idx) != low);
        return v;
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, " y_hi"}, {28'd0, hy3, hy2, hy1, hy0}, {28'd0, model_y(1'b0)});
        chk({tag, " y_lo"}, {28'd0, ly3, ly2, ly1, ly0}, {28'd0, model_y(1'b1)});
        chk({tag, " valid_hi"}, {31'd0, hvalid}, {31'd0, exp_idx >= 0});
        chk({tag, " valid_lo"}, {31'd0, lvalid}, {31'd0, exp_idx >= 0});
`ifdef DEC_HIT_COUNT_EN
        chk({tag, " cnt0"}, {30'd0, hc0}, exp_cnt[0]);
        chk({tag, " cnt1"}, {30'd0, hc1}, exp_cnt[1]);
        chk({tag, " cnt2"}, {30'd0, hc2}, exp_cnt[2]);
        chk({tag, " cnt3"}, {30'd0, hc3}, exp_cnt[3]);
        chk({tag, " cnt_lo"}, {24'd0, lc3, lc2, lc1, lc0}, {24'd0, hc3, hc2, hc1, hc0});
`endif
    endtask

    initial begin
        vec_t tbl [12];
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};

        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].sa, tbl[i].sb);
            chk($sformatf("tbl%0d y_hi", i), {28'd0, hy3, hy2, hy1, hy0}, {28'd0, tbl[i].y});
            chk($sformatf("tbl%0d y_lo", i), {28'd0, ly3, ly2, ly1, ly0}, {28'd0, ~tbl[i].y});
            chk($sformatf("tbl%0d valid", i), {30'd0, lvalid, hvalid}, {30'd0, tbl[i].v, tbl[i].v});
        end

`ifdef DEC_HIT_COUNT_EN
        begin
            int want [5];
            want = '{1, 2, 3, 3, 3};
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0);
                chk($sformatf("sat%0d cnt0", i), {30'd0, hc0}, want[i]);
                chk($sformatf("sat%0d others", i), {26'd0, hc3, hc2, hc1}, 32'd0);
            end
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("sat rst cnts", {24'd0, hc3, hc2, hc1, hc0}, 32'd0);
        end
`endif

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), 1'($urandom));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
